// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM and the ALU it drives.
package ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXE_R    = 4'd2,
        WB_R     = 4'd3,
        EXE_I    = 4'd4,
        WB_I     = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        WB_MEM   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        JAL      = 4'd12
    } state_t;

    typedef enum logic [4:0] {
        ALU_IDLE = 5'd0,  ALU_ADD = 5'd1,  ALU_SUB = 5'd2,  ALU_AND = 5'd3,
        ALU_OR   = 5'd4,  ALU_XOR = 5'd5,  ALU_NOR = 5'd6,  ALU_CMP = 5'd7,
        ALU_CMPU = 5'd8,  ALU_SL  = 5'd9,  ALU_SR  = 5'd10, ALU_SRA = 5'd11,
        ALU_LUI  = 5'd12, ALU_XAL = 5'd13
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E, OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

    localparam logic [1:0] SRCA_PC = 2'd0, SRCA_RS = 2'd1, SRCA_SHAMT = 2'd2;
    localparam logic [2:0] SRCB_RT = 3'd0, SRCB_FOUR = 3'd1, SRCB_SEXT = 3'd2;
    localparam logic [2:0] SRCB_ZEXT = 3'd3, SRCB_SEXT_SH2 = 3'd4;
    localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JTGT = 2'd2, PC_RS = 2'd3;
    localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
endpackage

// File: rtl/alu_op_decoder.sv
// Maps (state, opcode, funct) to the ALU operation and the shamt srcA select.
module alu_op_decoder
    import ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output alu_op_t     alu_op,
    output logic        shamt_sel
);
    always_comb begin
        alu_op    = ALU_IDLE;
        shamt_sel = 1'b0;
        case (state)
            FETCH, DECODE, MEM_ADDR: alu_op = ALU_ADD;
            BRANCH:                  alu_op = ALU_SUB;
            JAL:                     alu_op = ALU_XAL;
            EXE_R: begin
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_CMP;
                    FN_SLTU:         alu_op = ALU_CMPU;
                    FN_SLL: begin alu_op = ALU_SL;  shamt_sel = 1'b1; end
                    FN_SRL: begin alu_op = ALU_SR;  shamt_sel = 1'b1; end
                    FN_SRA: begin alu_op = ALU_SRA; shamt_sel = 1'b1; end
                    default:         alu_op = ALU_IDLE;
                endcase
            end
            EXE_I: begin
                case (opcode)
                    OP_ADDI, OP_ADDIU: alu_op = ALU_ADD;
                    OP_SLTI:           alu_op = ALU_CMP;
                    OP_SLTIU:          alu_op = ALU_CMPU;
                    OP_ANDI:           alu_op = ALU_AND;
                    OP_ORI:            alu_op = ALU_OR;
                    OP_XORI:           alu_op = ALU_XOR;
                    OP_LUI:            alu_op = ALU_LUI;
                    default:           alu_op = ALU_IDLE;
                endcase
            end
            default: alu_op = ALU_IDLE;
        endcase
    end
endmodule

// File: rtl/ctrl_fsm.sv
// Multicycle MIPS-style control FSM: registered state, combinational datapath controls.
module ctrl_fsm
    import ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_CTRL_opcode,
    input  logic [5:0] i_CTRL_funct,
    input  logic       i_CTRL_zero,
    output logic       o_CTRL_pcWrite,
    output logic       o_CTRL_irWrite,
    output logic       o_CTRL_memRead,
    output logic       o_CTRL_memWrite,
    output logic       o_CTRL_regWrite,
    output logic       o_CTRL_iOrD,
    output logic [1:0] o_CTRL_regDst,
    output logic       o_CTRL_memToReg,
    output logic [1:0] o_CTRL_srcASel,
    output logic [2:0] o_CTRL_srcBSel,
    output logic [1:0] o_CTRL_pcSrc,
    output logic [4:0] o_CTRL_aluOp,
    output logic [3:0] o_CTRL_state
);
    state_t  state;
    alu_op_t alu_op;
    logic    shamt_sel;

    alu_op_decoder u_dec (
        .state     (state),
        .opcode    (i_CTRL_opcode),
        .funct     (i_CTRL_funct),
        .alu_op    (alu_op),
        .shamt_sel (shamt_sel)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH: state <= DECODE;
                DECODE: begin
                    if (i_CTRL_opcode == OP_RTYPE)                      state <= EXE_R;
                    else if (i_CTRL_opcode == OP_LW || i_CTRL_opcode == OP_SW) state <= MEM_ADDR;
                    else if (i_CTRL_opcode[5:3] == 3'b001)              state <= EXE_I;
                    else if (i_CTRL_opcode == OP_BEQ || i_CTRL_opcode == OP_BNE) state <= BRANCH;
                    else if (i_CTRL_opcode == OP_J)                     state <= JUMP;
                    else if (i_CTRL_opcode == OP_JAL)                   state <= JAL;
                    else                                                state <= FETCH;
                end
                EXE_R:    state <= (alu_op != ALU_IDLE) ? WB_R : FETCH;
                EXE_I:    state <= WB_I;
                MEM_ADDR: state <= (i_CTRL_opcode == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD:   state <= WB_MEM;
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        o_CTRL_pcWrite  = 1'b0;
        o_CTRL_irWrite  = 1'b0;
        o_CTRL_memRead  = 1'b0;
        o_CTRL_memWrite = 1'b0;
        o_CTRL_regWrite = 1'b0;
        o_CTRL_iOrD     = 1'b0;
        o_CTRL_regDst   = RD_RT;
        o_CTRL_memToReg = 1'b0;
        o_CTRL_srcASel  = SRCA_PC;
        o_CTRL_srcBSel  = SRCB_RT;
        o_CTRL_pcSrc    = PC_ALU;
        case (state)
            FETCH: begin
                o_CTRL_memRead = 1'b1;
                o_CTRL_irWrite = 1'b1;
                o_CTRL_srcBSel = SRCB_FOUR;
                o_CTRL_pcWrite = 1'b1;
            end
            DECODE: o_CTRL_srcBSel = SRCB_SEXT_SH2;
            EXE_R: begin
                if (shamt_sel)                o_CTRL_srcASel = SRCA_SHAMT;
                else if (alu_op != ALU_IDLE)  o_CTRL_srcASel = SRCA_RS;
                if (i_CTRL_funct == FN_JR) begin
                    o_CTRL_pcWrite = 1'b1;
                    o_CTRL_pcSrc   = PC_RS;
                end
            end
            WB_R: begin
                o_CTRL_regWrite = 1'b1;
                o_CTRL_regDst   = RD_RD;
            end
            EXE_I: begin
                o_CTRL_srcASel = SRCA_RS;
                o_CTRL_srcBSel = (i_CTRL_opcode[2]) ? SRCB_ZEXT : SRCB_SEXT;
            end
            WB_I: o_CTRL_regWrite = 1'b1;
            MEM_ADDR: begin
                o_CTRL_srcASel = SRCA_RS;
                o_CTRL_srcBSel = SRCB_SEXT;
            end
            MEM_RD: begin
                o_CTRL_memRead = 1'b1;
                o_CTRL_iOrD    = 1'b1;
            end
            WB_MEM: begin
                o_CTRL_regWrite = 1'b1;
                o_CTRL_memToReg = 1'b1;
            end
            MEM_WR: begin
                o_CTRL_memWrite = 1'b1;
                o_CTRL_iOrD     = 1'b1;
            end
            BRANCH: begin
                o_CTRL_srcASel = SRCA_RS;
                o_CTRL_pcSrc   = PC_ALUOUT;
                o_CTRL_pcWrite = (i_CTRL_opcode == OP_BNE) ? !i_CTRL_zero : i_CTRL_zero;
            end
            JUMP: begin
                o_CTRL_pcWrite = 1'b1;
                o_CTRL_pcSrc   = PC_JTGT;
            end
            JAL: begin
                o_CTRL_pcWrite  = 1'b1;
                o_CTRL_pcSrc    = PC_JTGT;
                o_CTRL_regWrite = 1'b1;
                o_CTRL_regDst   = RD_RA;
            end
            default: ;
        endcase
        // state already reads FETCH during reset; its strobes must still be held off
        if (i_rst) begin
            o_CTRL_pcWrite  = 1'b0;
            o_CTRL_irWrite  = 1'b0;
            o_CTRL_memRead  = 1'b0;
            o_CTRL_memWrite = 1'b0;
            o_CTRL_regWrite = 1'b0;
        end
    end

    assign o_CTRL_aluOp = alu_op;
    assign o_CTRL_state = state;
endmodule

// File: tb/tb_ctrl_fsm.sv
// Scoreboard bench: stimulus queues hand-computed per-cycle outputs, a negedge monitor checks them.
module tb_ctrl_fsm;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero;
    logic       pcw, irw, mr, mw, rw, iord, m2r;
    logic [1:0] rd, sa, ps;
    logic [2:0] sb;
    logic [4:0] alu;
    logic [3:0] st;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] st;
        logic [5:0] strb;   // {pcWrite, irWrite, memRead, memWrite, regWrite, iOrD}
        logic [1:0] rd;
        logic       m2r;
        logic [1:0] sa;
        logic [2:0] sb;
        logic [1:0] ps;
        logic [4:0] alu;
    } ev_t;

    ev_t   q[$];
    string nq[$];

    always #5 clk = ~clk;

    ctrl_fsm dut (
        .i_clk(clk), .i_rst(rst),
        .i_CTRL_opcode(opcode), .i_CTRL_funct(funct), .i_CTRL_zero(zero),
        .o_CTRL_pcWrite(pcw), .o_CTRL_irWrite(irw), .o_CTRL_memRead(mr),
        .o_CTRL_memWrite(mw), .o_CTRL_regWrite(rw), .o_CTRL_iOrD(iord),
        .o_CTRL_regDst(rd), .o_CTRL_memToReg(m2r), .o_CTRL_srcASel(sa),
        .o_CTRL_srcBSel(sb), .o_CTRL_pcSrc(ps), .o_CTRL_aluOp(alu), .o_CTRL_state(st)
    );

    function automatic ev_t mk(input logic [3:0] s, input logic [5:0] strb, input logic [1:0] r,
                               input logic m, input logic [1:0] a, input logic [2:0] b,
                               input logic [1:0] p, input logic [4:0] op);
        ev_t e;
        e = '{st: s, strb: strb, rd: r, m2r: m, sa: a, sb: b, ps: p, alu: op};
        return e;
    endfunction

    function automatic ev_t actual();
        return mk(st, {pcw, irw, mr, mw, rw, iord}, rd, m2r, sa, sb, ps, alu);
    endfunction

    task automatic push(input string n, input ev_t e);
        q.push_back(e);
        nq.push_back(n);
    endtask

    task automatic fetch_decode(input string n);
        push({n, ".fetch"},  mk(4'd0, 6'b111000, 2'd0, 1'b0, 2'd0, 3'd1, 2'd0, 5'd1));
        push({n, ".decode"}, mk(4'd1, 6'b000000, 2'd0, 1'b0, 2'd0, 3'd4, 2'd0, 5'd1));
    endtask

    task automatic setir(input logic [5:0] o, input logic [5:0] f, input logic z);
        opcode = o; funct = f; zero = z;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input ev_t got, input ev_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", n, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) chk(nq.pop_front(), actual(), q.pop_front());
    end

    initial begin
        rst = 1'b1;
        setir(6'h00, 6'h20, 1'b0);
        #2;
        chk("reset_async", actual(), mk(4'd0, 6'b000000, 2'd0, 1'b0, 2'd0, 3'd1, 2'd0, 5'd1));
        cycles(2);
        chk("reset_held", actual(), mk(4'd0, 6'b000000, 2'd0, 1'b0, 2'd0, 3'd1, 2'd0, 5'd1));
        rst = 1'b0;

        // add $3,$1,$2
        setir(6'h00, 6'h20, 1'b0); fetch_decode("add");
        push("add.exe", mk(4'd2, 6'b000000, 2'd0, 1'b0, 2'd1, 3'd0, 2'd0, 5'd1));
        push("add.wb",  mk(4'd3, 6'b000010, 2'd1, 1'b0, 2'd0, 3'd0, 2'd0, 5'd0));
        cycles(4);
        // lw
        setir(6'h23, 6'h00, 1'b0); fetch_decode("lw");
        push("lw.addr", mk(4'd6, 6'b000000, 2'd0, 1'b0, 2'd1, 3'd2, 2'd0, 5'd1));
        push("lw.rd",   mk(4'd7, 6'b001001, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 5'd0));
        push("lw.wb",   mk(4'd8, 6'b000010, 2'd0, 1'b1, 2'd0, 3'd0, 2'd0, 5'd0));
        cycles(5);
        // sw
        setir(6'h2B, 6'h00, 1'b0); fetch_decode("sw");
        push("sw.addr", mk(4'd6, 6'b000000, 2'd0, 1'b0, 2'd1, 3'd2, 2'd0, 5'd1));
        push("sw.wr",   mk(4'd9, 6'b000101, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 5'd0));
        cycles(4);
        // beq/bne, zero 1 and 0
        setir(6'h04, 6'h00, 1'b1); fetch_decode("beq1");
        push("beq1.br", mk(4'd10, 6'b100000, 2'd0, 1'b0, 2'd1, 3'd0, 2'd1, 5'd2));
        cycles(3);
        setir(6'h04, 6'h00, 1'b0); fetch_decode("beq0");
        push("beq0.br", mk(4'd10, 6'b000000, 2'd0, 1'b0, 2'd1, 3'd0, 2'd1, 5'd2));
        cycles(3);
        setir(6'h05, 6'h00, 1'b1); fetch_decode("bne1");
        push("bne1.br", mk(4'd10, 6'b000000, 2'd0, 1'b0, 2'd1, 3'd0, 2'd1, 5'd2));
        cycles(3);
        setir(6'h05, 6'h00, 1'b0); fetch_decode("bne0");
        push("bne0.br", mk(4'd10, 6'b100000, 2'd0, 1'b0, 2'd1, 3'd0, 2'd1, 5'd2));
        cycles(3);
        // sll / sra
        setir(6'h00, 6'h00, 1'b0); fetch_decode("sll");
        push("sll.exe", mk(4'd2, 6'b000000, 2'd0, 1'b0, 2'd2, 3'd0, 2'd0, 5'd9));
        push("sll.wb",  mk(4'd3, 6'b000010, 2'd1, 1'b0, 2'd0, 3'd0, 2'd0, 5'd0));
        cycles(4);
        setir(6'h00, 6'h03, 1'b0); fetch_decode("sra");
        push("sra.exe", mk(4'd2, 6'b000000, 2'd0, 1'b0, 2'd2, 3'd0, 2'd0, 5'd11));
        push("sra.wb",  mk(4'd3, 6'b000010, 2'd1, 1'b0, 2'd0, 3'd0, 2'd0, 5'd0));
        cycles(4);
        // lui, slti
        setir(6'h0F, 6'h00, 1'b0); fetch_decode("lui");
        push("lui.exe", mk(4'd4, 6'b000000, 2'd0, 1'b0, 2'd1, 3'd3, 2'd0, 5'd12));
        push("lui.wb",  mk(4'd5, 6'b000010, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 5'd0));
        cycles(4);
        setir(6'h0A, 6'h00, 1'b0); fetch_decode("slti");
        push("slti.exe", mk(4'd4, 6'b000000, 2'd0, 1'b0, 2'd1, 3'd2, 2'd0, 5'd7));
        push("slti.wb",  mk(4'd5, 6'b000010, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 5'd0));
        cycles(4);
        // jal, j, jr
        setir(6'h03, 6'h00, 1'b0); fetch_decode("jal");
        push("jal.exe", mk(4'd12, 6'b100010, 2'd2, 1'b0, 2'd0, 3'd0, 2'd2, 5'd13));
        cycles(3);
        setir(6'h02, 6'h00, 1'b0); fetch_decode("j");
        push("j.exe", mk(4'd11, 6'b100000, 2'd0, 1'b0, 2'd0, 3'd0, 2'd2, 5'd0));
        cycles(3);
        setir(6'h00, 6'h08, 1'b0); fetch_decode("jr");
        push("jr.exe", mk(4'd2, 6'b100000, 2'd0, 1'b0, 2'd0, 3'd0, 2'd3, 5'd0));
        cycles(3);
        // unlisted funct, illegal opcode
        setir(6'h00, 6'h3F, 1'b0); fetch_decode("badfn");
        push("badfn.exe", mk(4'd2, 6'b000000, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 5'd0));
        cycles(3);
        setir(6'h3F, 6'h00, 1'b0); fetch_decode("illegal");
        cycles(2);
        // reset pulse in MEM_RD of a lw
        setir(6'h23, 6'h00, 1'b0); fetch_decode("lwrst");
        push("lwrst.addr", mk(4'd6, 6'b000000, 2'd0, 1'b0, 2'd1, 3'd2, 2'd0, 5'd1));
        cycles(3);
        chk("rst.pre", actual(), mk(4'd7, 6'b001001, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 5'd0));
        #2 rst = 1'b1;
        #1 chk("rst.async", actual(), mk(4'd0, 6'b000000, 2'd0, 1'b0, 2'd0, 3'd1, 2'd0, 5'd1));
        cycles(1);
        chk("rst.hold", actual(), mk(4'd0, 6'b000000, 2'd0, 1'b0, 2'd0, 3'd1, 2'd0, 5'd1));
        rst = 1'b0;
        setir(6'h00, 6'h25, 1'b0); fetch_decode("or");
        push("or.exe", mk(4'd2, 6'b000000, 2'd0, 1'b0, 2'd1, 3'd0, 2'd0, 5'd4));
        push("or.wb",  mk(4'd3, 6'b000010, 2'd1, 1'b0, 2'd0, 3'd0, 2'd0, 5'd0));
        cycles(4);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: left=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
